// File: rtl/hdng_pid_ctrl.sv
// Heading-hold PID controller: wrapped heading error -> saturated P/I/D terms ->
// differential wheel speed commands, three registered stages, one sample per cycle.
module hdng_pid_ctrl #(
    parameter int HDNG_W    = 12,
    parameter int ERR_W     = 10,
    parameter int SPD_W     = 11,
    parameter int INT_W     = 16,
    parameter int I_SHIFT   = 4,
    parameter int P_COEFF   = 3,
    parameter int D_COEFF   = 14,
    parameter int D_W       = 8,
    parameter int D_TAPS    = 2,
    parameter int OUT_SHIFT = 3,
    parameter int AT_THR    = 30,
    parameter int AT_HYST   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     moving,
    input  logic signed [HDNG_W-1:0] dsrd_hdng,
    input  logic signed [HDNG_W-1:0] actl_hdng,
    input  logic                     hdng_vld,
    input  logic        [SPD_W-1:0]  frwrd_spd,
    output logic                     at_hdng,
    output logic signed [SPD_W:0]    lft_spd,
    output logic signed [SPD_W:0]    rght_spd,
    output logic                     pid_vld
);

    localparam int P_W   = ERR_W + 5;
    localparam int DT_W  = D_W + 5;
    localparam int SUM_W = ((INT_W > P_W) ? INT_W : P_W) + 2;
    localparam int OUT_W = SPD_W + 1;

    localparam logic signed [HDNG_W-1:0] ERR_MAX = HDNG_W'((1 << (ERR_W - 1)) - 1);
    localparam logic signed [HDNG_W-1:0] ERR_MIN = HDNG_W'(-(1 << (ERR_W - 1)));
    localparam logic signed [ERR_W:0]    DIF_MAX = (ERR_W + 1)'((1 << (D_W - 1)) - 1);
    localparam logic signed [ERR_W:0]    DIF_MIN = (ERR_W + 1)'(-(1 << (D_W - 1)));
    localparam logic signed [INT_W:0]    INT_MAX = (INT_W + 1)'((1 << (INT_W - 1)) - 1);
    localparam logic signed [INT_W:0]    INT_MIN = (INT_W + 1)'(-(1 << (INT_W - 1)));
    localparam logic signed [SUM_W-1:0]  S_MAX   = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0]  S_MIN   = SUM_W'(-(1 << (OUT_W - 1)));
    localparam logic signed [OUT_W:0]    O_MAX   = (OUT_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [OUT_W:0]    O_MIN   = (OUT_W + 1)'(-(1 << (OUT_W - 1)));
    localparam logic signed [ERR_W:0]    THR_SET = (ERR_W + 1)'(AT_THR);
    localparam logic signed [ERR_W:0]    THR_CLR = (ERR_W + 1)'(AT_THR + AT_HYST);
    localparam logic signed [P_W-1:0]    P_K     = P_W'(P_COEFF);
    localparam logic signed [DT_W-1:0]   D_K     = DT_W'(D_COEFF);

    logic signed [HDNG_W-1:0] err_wrap_s;
    logic signed [ERR_W-1:0]  err_sat_s, err_q;
    logic                     vld_s1_q, vld_s2_q;
    logic signed [ERR_W-1:0]  hist_q [D_TAPS];
    logic signed [ERR_W:0]    err_ext_s, err_abs_s, diff_full_s;
    logic signed [D_W-1:0]    diff_sat_s;
    logic signed [INT_W:0]    integ_sum_s;
    logic signed [INT_W-1:0]  integ_sat_s, integ_d, integ_q;
    logic signed [P_W-1:0]    p_s, p_q;
    logic signed [DT_W-1:0]   d_s, d_q;
    logic signed [INT_W-1:0]  i_s, i_q;
    logic                     at_hdng_d, at_hdng_q;
    logic signed [SUM_W-1:0]  sum_s, sum_shr_s;
    logic signed [OUT_W-1:0]  s_sat_s;
    logic signed [OUT_W:0]    fwd_ext_s, s_ext_s, lft_full_s, rght_full_s;
    logic signed [OUT_W-1:0]  lft_d, rght_d, lft_q, rght_q;
    logic                     pid_vld_q;

    // Stage 0: subtraction wraps naturally at HDNG_W, then clamp to the error range.
    always_comb begin
        err_wrap_s = actl_hdng - dsrd_hdng;
        if (err_wrap_s > ERR_MAX) begin
            err_sat_s = ERR_MAX[ERR_W-1:0];
        end else if (err_wrap_s < ERR_MIN) begin
            err_sat_s = ERR_MIN[ERR_W-1:0];
        end else begin
            err_sat_s = err_wrap_s[ERR_W-1:0];
        end
    end

    // Stage 1 terms, saturating integrator and hysteretic at-heading decision.
    always_comb begin
        err_ext_s   = {err_q[ERR_W-1], err_q};
        diff_full_s = err_ext_s - {hist_q[D_TAPS-1][ERR_W-1], hist_q[D_TAPS-1]};
        if (diff_full_s > DIF_MAX) begin
            diff_sat_s = DIF_MAX[D_W-1:0];
        end else if (diff_full_s < DIF_MIN) begin
            diff_sat_s = DIF_MIN[D_W-1:0];
        end else begin
            diff_sat_s = diff_full_s[D_W-1:0];
        end
        p_s = P_W'(err_q) * P_K;
        d_s = DT_W'(diff_sat_s) * D_K;

        integ_sum_s = (INT_W + 1)'(integ_q) + (INT_W + 1)'(err_q);
        if (integ_sum_s > INT_MAX) begin
            integ_sat_s = INT_MAX[INT_W-1:0];
        end else if (integ_sum_s < INT_MIN) begin
            integ_sat_s = INT_MIN[INT_W-1:0];
        end else begin
            integ_sat_s = integ_sum_s[INT_W-1:0];
        end
        // Drive disabled wins over any update, so the I term of that sample is also 0.
        if (!moving) begin
            integ_d = '0;
        end else if (vld_s1_q) begin
            integ_d = integ_sat_s;
        end else begin
            integ_d = integ_q;
        end
        i_s = integ_d >>> I_SHIFT;

        err_abs_s = err_ext_s[ERR_W] ? -err_ext_s : err_ext_s;
        if (err_abs_s < THR_SET) begin
            at_hdng_d = 1'b1;
        end else if (err_abs_s >= THR_CLR) begin
            at_hdng_d = 1'b0;
        end else begin
            at_hdng_d = at_hdng_q;
        end
    end

    // Stage 2: combine terms, scale, then mix into the two wheel commands.
    always_comb begin
        sum_s     = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(d_q);
        sum_shr_s = sum_s >>> OUT_SHIFT;
        if (sum_shr_s > S_MAX) begin
            s_sat_s = S_MAX[OUT_W-1:0];
        end else if (sum_shr_s < S_MIN) begin
            s_sat_s = S_MIN[OUT_W-1:0];
        end else begin
            s_sat_s = sum_shr_s[OUT_W-1:0];
        end
        fwd_ext_s   = $signed({2'b00, frwrd_spd});
        s_ext_s     = (OUT_W + 1)'(s_sat_s);
        lft_full_s  = fwd_ext_s + s_ext_s;
        rght_full_s = fwd_ext_s - s_ext_s;
        if (lft_full_s > O_MAX) begin
            lft_d = O_MAX[OUT_W-1:0];
        end else if (lft_full_s < O_MIN) begin
            lft_d = O_MIN[OUT_W-1:0];
        end else begin
            lft_d = lft_full_s[OUT_W-1:0];
        end
        if (rght_full_s > O_MAX) begin
            rght_d = O_MAX[OUT_W-1:0];
        end else if (rght_full_s < O_MIN) begin
            rght_d = O_MIN[OUT_W-1:0];
        end else begin
            rght_d = rght_full_s[OUT_W-1:0];
        end
    end

    // Pipeline, history, integrator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= '0;
            vld_s1_q  <= 1'b0;
            vld_s2_q  <= 1'b0;
            for (int k = 0; k < D_TAPS; k++) hist_q[k] <= '0;
            integ_q   <= '0;
            p_q       <= '0;
            d_q       <= '0;
            i_q       <= '0;
            at_hdng_q <= 1'b0;
            lft_q     <= '0;
            rght_q    <= '0;
            pid_vld_q <= 1'b0;
        end else begin
            vld_s1_q <= hdng_vld;
            vld_s2_q <= vld_s1_q;
            integ_q  <= integ_d;
            if (hdng_vld) begin
                err_q <= err_sat_s;
            end
            if (vld_s1_q) begin
                p_q       <= p_s;
                d_q       <= d_s;
                i_q       <= i_s;
                at_hdng_q <= at_hdng_d;
                for (int k = D_TAPS - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
                hist_q[0] <= err_q;
            end
            if (!moving) begin
                lft_q  <= '0;
                rght_q <= '0;
            end else if (vld_s2_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
            pid_vld_q <= vld_s2_q & moving;
        end
    end

    assign at_hdng  = at_hdng_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign pid_vld  = pid_vld_q;

endmodule

// File: tb/tb_hdng_pid_ctrl.sv
// Self-checking bench for hdng_pid_ctrl: directed scenarios plus a randomized
// stream compared cycle by cycle with an integer behavioural model.
module tb_hdng_pid_ctrl;

    localparam int HDNG_W = 12;
    localparam int SPD_W  = 11;
    localparam int OUT_W  = SPD_W + 1;
    localparam int D_TAPS = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     moving;
    logic                     hdng_vld;
    logic signed [HDNG_W-1:0] dsrd_hdng;
    logic signed [HDNG_W-1:0] actl_hdng;
    logic        [SPD_W-1:0]  frwrd_spd;
    logic                     at_hdng;
    logic                     pid_vld;
    logic signed [OUT_W-1:0]  lft_spd;
    logic signed [OUT_W-1:0]  rght_spd;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (plain integers)
    bit m_v1, m_v2, m_at, m_pv;
    int m_e1, m_p, m_i, m_d, m_integ, m_lft, m_rght;
    int m_hist[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hdng_pid_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .moving    (moving),
        .dsrd_hdng (dsrd_hdng),
        .actl_hdng (actl_hdng),
        .hdng_vld  (hdng_vld),
        .frwrd_spd (frwrd_spd),
        .at_hdng   (at_hdng),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .pid_vld   (pid_vld)
    );

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int absi(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_v1 = 1'b0; m_v2 = 1'b0; m_at = 1'b0; m_pv = 1'b0;
        m_e1 = 0; m_p = 0; m_i = 0; m_d = 0; m_integ = 0; m_lft = 0; m_rght = 0;
        m_hist = {};
        for (int k = 0; k < D_TAPS; k++) m_hist.push_back(0);
    endtask

    // One clock edge of the controller, computed from the rules with integers.
    task automatic model_step();
        int w, s, diff, integ_new;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!moving) begin
            m_lft = 0; m_rght = 0;
        end else if (m_v2) begin
            s      = clampi((m_p + m_i + m_d) >>> 3, -2048, 2047);
            m_lft  = clampi(int'(frwrd_spd) + s, -2048, 2047);
            m_rght = clampi(int'(frwrd_spd) - s, -2048, 2047);
        end
        m_pv = m_v2 && moving;
        if (!moving)   integ_new = 0;
        else if (m_v1) integ_new = clampi(m_integ + m_e1, -32768, 32767);
        else           integ_new = m_integ;
        if (m_v1) begin
            m_p  = m_e1 * 3;
            diff = clampi(m_e1 - m_hist[D_TAPS-1], -128, 127);
            m_d  = diff * 14;
            m_i  = integ_new >>> 4;
            if (absi(m_e1) < 30)       m_at = 1'b1;
            else if (absi(m_e1) >= 38) m_at = 1'b0;
            m_hist.push_front(m_e1);
            void'(m_hist.pop_back());
        end
        m_integ = integ_new;
        m_v2    = m_v1;
        if (hdng_vld) begin
            w = int'(actl_hdng) - int'(dsrd_hdng);
            if (w > 2047)       w -= 4096;
            else if (w < -2048) w += 4096;
            m_e1 = clampi(w, -512, 511);
        end
        m_v1 = hdng_vld;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; hdng_vld = 1'b0; moving = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; moving = 1'b0; hdng_vld = 1'b0;
        dsrd_hdng = '0; actl_hdng = '0; frwrd_spd = '0;
        model_reset();
        tick(); tick();
        checks++;
        if ({at_hdng, pid_vld, lft_spd, rght_spd} !== 26'd0) begin
            failures++;
            $display("FAIL reset_state act at=%0b vld=%0b l=%0d r=%0d exp all 0", at_hdng, pid_vld, lft_spd, rght_spd);
        end
        rst_n = 1'b1; moving = 1'b1; frwrd_spd = 11'd700;
        for (int k = 0; k < 6; k++) begin
            hdng_vld  = 1'b1;
            actl_hdng = HDNG_W'($urandom_range(0, 200));
            tick();
            checks++;
            if ({at_hdng, pid_vld, lft_spd, rght_spd} !== {m_at, m_pv, OUT_W'(m_lft), OUT_W'(m_rght)}) begin
                failures++;
                $display("FAIL reset_stream act at=%0b vld=%0b l=%0d r=%0d exp at=%0b vld=%0b l=%0d r=%0d",
                         at_hdng, pid_vld, lft_spd, rght_spd, m_at, m_pv, m_lft, m_rght);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({at_hdng, pid_vld, lft_spd, rght_spd} !== 26'd0) begin
            failures++;
            $display("FAIL reset_async act at=%0b vld=%0b l=%0d r=%0d exp all 0", at_hdng, pid_vld, lft_spd, rght_spd);
        end
        model_reset();
        tick();
        rst_n = 1'b1; hdng_vld = 1'b0;
        tick();
        checks++;
        if (pid_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_vld act pid_vld=%0b exp 0", pid_vld);
        end
        hdng_vld = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (pid_vld === 1'b1 && lat == 0) lat = k;
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL reset_latency act first pid_vld at edge %0d exp edge 3 (0 = never)", lat);
        end
        hdng_vld = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        moving = 1'b1; frwrd_spd = 11'd512; dsrd_hdng = 12'sd0; actl_hdng = 12'sd16;
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        tick();
        checks++;
        if ({at_hdng, pid_vld} !== 2'b10) begin
            failures++;
            $display("FAIL basic_n1 act at=%0b vld=%0b exp at=1 vld=0", at_hdng, pid_vld);
        end
        tick();
        checks++;
        if (pid_vld !== 1'b1 || lft_spd !== 12'sd546 || rght_spd !== 12'sd478) begin
            failures++;
            $display("FAIL basic_n2 act vld=%0b l=%0d r=%0d exp vld=1 l=546 r=478", pid_vld, lft_spd, rght_spd);
        end
        tick();
        checks++;
        if (pid_vld !== 1'b0 || lft_spd !== 12'sd546 || rght_spd !== 12'sd478) begin
            failures++;
            $display("FAIL basic_hold act vld=%0b l=%0d r=%0d exp vld=0 l=546 r=478", pid_vld, lft_spd, rght_spd);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        moving = 1'b1; frwrd_spd = 11'd2047; dsrd_hdng = 12'sd0; actl_hdng = 12'sd1024;
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        tick();
        checks++;
        if ({at_hdng, pid_vld} !== 2'b00) begin
            failures++;
            $display("FAIL sat_n1 act at=%0b vld=%0b exp at=0 vld=0", at_hdng, pid_vld);
        end
        tick();
        checks++;
        if (pid_vld !== 1'b1 || lft_spd !== 12'sd2047 || rght_spd !== 12'sd1630) begin
            failures++;
            $display("FAIL sat_out act vld=%0b l=%0d r=%0d exp vld=1 l=2047 r=1630", pid_vld, lft_spd, rght_spd);
        end
    endtask

    task automatic test_integ_rail();
        apply_reset();
        moving = 1'b1; frwrd_spd = 11'd1000; dsrd_hdng = 12'sd0; actl_hdng = 12'sd1024;
        hdng_vld = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            checks++;
            if ({at_hdng, pid_vld, lft_spd, rght_spd} !== {m_at, m_pv, OUT_W'(m_lft), OUT_W'(m_rght)}) begin
                failures++;
                $display("FAIL rail_stream k=%0d act l=%0d r=%0d vld=%0b exp l=%0d r=%0d vld=%0b",
                         k, lft_spd, rght_spd, pid_vld, m_lft, m_rght, m_pv);
            end
        end
        checks++;
        if (lft_spd !== 12'sd1447 || rght_spd !== 12'sd553) begin
            failures++;
            $display("FAIL rail_steady act l=%0d r=%0d exp l=1447 r=553", lft_spd, rght_spd);
        end
        moving = 1'b0;
        tick();
        checks++;
        if (pid_vld !== 1'b0 || lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
            failures++;
            $display("FAIL rail_stop act vld=%0b l=%0d r=%0d exp vld=0 l=0 r=0", pid_vld, lft_spd, rght_spd);
        end
        moving = 1'b1;
        tick(); tick();
        checks++;
        if (pid_vld !== 1'b1 || lft_spd !== 12'sd1195 || rght_spd !== 12'sd805) begin
            failures++;
            $display("FAIL rail_restart act vld=%0b l=%0d r=%0d exp vld=1 l=1195 r=805", pid_vld, lft_spd, rght_spd);
        end
        hdng_vld = 1'b0;
    endtask

    task automatic test_hysteresis();
        int errs [5] = '{29, 35, 40, 33, 20};
        bit exp_at [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        moving = 1'b1; frwrd_spd = 11'd512; dsrd_hdng = 12'sd0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                hdng_vld  = 1'b1;
                actl_hdng = HDNG_W'(errs[k]);
            end else begin
                hdng_vld = 1'b0;
            end
            tick();
            if (k >= 1) begin
                checks++;
                if (at_hdng !== exp_at[k-1]) begin
                    failures++;
                    $display("FAIL hyst err=%0d act at_hdng=%0b exp %0b", errs[k-1], at_hdng, exp_at[k-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        moving = 1'b1; frwrd_spd = 11'd512; dsrd_hdng = -12'sd2040; actl_hdng = 12'sd2040;
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        tick();
        checks++;
        if (at_hdng !== 1'b1) begin
            failures++;
            $display("FAIL wrap_at act at_hdng=%0b exp 1", at_hdng);
        end
        tick();
        checks++;
        if (pid_vld !== 1'b1 || lft_spd !== 12'sd477 || rght_spd !== 12'sd547) begin
            failures++;
            $display("FAIL wrap_out act vld=%0b l=%0d r=%0d exp vld=1 l=477 r=547", pid_vld, lft_spd, rght_spd);
        end
    endtask

    task automatic test_random();
        int base;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            hdng_vld  = ($urandom_range(0, 9) < 7);
            moving    = ($urandom_range(0, 19) != 0);
            frwrd_spd = SPD_W'($urandom_range(0, 2047));
            base      = $urandom_range(0, 4095) - 2048;
            dsrd_hdng = HDNG_W'(base);
            if ($urandom_range(0, 1) == 1) actl_hdng = HDNG_W'(base + $urandom_range(0, 120) - 60);
            else                           actl_hdng = HDNG_W'($urandom_range(0, 4095));
            tick();
            checks++;
            if ({at_hdng, pid_vld, lft_spd, rght_spd} !== {m_at, m_pv, OUT_W'(m_lft), OUT_W'(m_rght)}) begin
                failures++;
                $display("FAIL random k=%0d act at=%0b vld=%0b l=%0d r=%0d exp at=%0b vld=%0b l=%0d r=%0d",
                         k, at_hdng, pid_vld, lft_spd, rght_spd, m_at, m_pv, m_lft, m_rght);
            end
        end
        hdng_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_integ_rail();
        test_hysteresis();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
